// File: rtl/aurora_pkg.sv
//------------------------------------------------------------------------------
// Module   : aurora_pkg
// Brief    : Shared types and constants for the Aurora TX framer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package aurora_pkg;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        I    = 3'd1,
        SCP  = 3'd2,
        ECP  = 3'd3,
        CC   = 3'd4
    } ordered_sets_e;

    localparam int DEF_SINGLE_RATIO = 4;
    localparam int DEF_MULTI_RATIO  = 2;
    localparam int CNT_W            = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aurora_cc_timer.sv
//------------------------------------------------------------------------------
// Module   : aurora_cc_timer
// Brief    : Free-running clock-compensation period timer with a pending flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aurora_cc_timer
    import aurora_pkg::*;
#(
    parameter int PERIOD = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic take,
    output logic pending
);

    localparam int            TW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TW-1:0] TLAST = TW'(PERIOD - 1);

    logic [TW-1:0] r_cnt;
    logic          r_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            if (r_cnt == TLAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + TW'(1);
            end
            // A fresh request wins over a same-cycle take; extra requests merge.
            if (r_cnt == TLAST) begin
                r_pending <= 1'b1;
            end else if (take) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/aurora_tx_framer.sv
//------------------------------------------------------------------------------
// Module   : aurora_tx_framer
// Brief    : AXI-Stream to lane framer emitting SCP/data/ECP ordered sets.
//            Optional clock-compensation insertion under macro CC_INSERT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module aurora_tx_framer
    import aurora_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int SINGLE_RATIO = DEF_SINGLE_RATIO,
    parameter int MULTI_RATIO  = DEF_MULTI_RATIO,
    parameter int SCP_CYCLES   = 2,
    parameter int ECP_CYCLES   = 2,
    parameter int CC_PERIOD    = 5000,
    parameter int CC_CYCLES    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              single_lane,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic [DATA_W-1:0] s_axis_tdata,
    output ordered_sets_e     os_out,
    output logic [DATA_W-1:0] data_out,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOF    = 3'd1,
        ST_STREAM = 3'd2,
        ST_EOF    = 3'd3,
        ST_CC     = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] SCP_LAST = CNT_W'(SCP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECP_LAST = CNT_W'(ECP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CC_LAST  = CNT_W'(CC_CYCLES - 1);

    generate
        if (SCP_CYCLES < 1 || ECP_CYCLES < 1 || CC_CYCLES < 1 || CC_PERIOD < 1 ||
            SINGLE_RATIO < 1 || MULTI_RATIO < 1) begin : g_bad_param
            $error("aurora_tx_framer: cycle counts and ratios must be >= 1");
        end
    endgenerate

    state_e             r_state, w_nx_state;
    logic [CNT_W-1:0]   r_cnt, w_nx_cnt;
    logic [CNT_W-1:0]   r_ratio, w_nx_ratio;
    ordered_sets_e      r_os, w_nx_os;
    logic [DATA_W-1:0]  r_data, w_nx_data;
    logic [15:0]        r_frame_cnt, w_nx_fcnt;
    logic               r_last_acc, w_nx_last;
    logic               r_cc_ret, w_nx_cc_ret;
    logic               w_cc_req;
    logic               w_tready;
    logic               w_accept;
    logic               w_slot_end;
    logic [CNT_W-1:0]   w_ratio_sel;

`ifdef CC_INSERT_EN
    logic w_cc_take;

    assign w_cc_take = (w_nx_state == ST_CC) && (r_state != ST_CC);

    aurora_cc_timer #(
        .PERIOD (CC_PERIOD)
    ) u_cc_timer (
        .clk     (clk),
        .rst     (rst),
        .take    (w_cc_take),
        .pending (w_cc_req)
    );
`else
    assign w_cc_req = 1'b0;
`endif

    assign w_ratio_sel = single_lane ? CNT_W'(SINGLE_RATIO) : CNT_W'(MULTI_RATIO);
    assign w_slot_end  = (r_cnt == r_ratio - CNT_W'(1));
    assign w_accept    = s_axis_tvalid && w_tready;

    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            ST_SOF:    w_tready = (r_cnt == SCP_LAST);
            ST_STREAM: w_tready = w_slot_end && !r_last_acc && !w_cc_req;
            ST_CC:     w_tready = (r_cnt == CC_LAST) && r_cc_ret;
            default:   w_tready = 1'b0;
        endcase
    end

    always_comb begin
        w_nx_state  = r_state;
        w_nx_cnt    = r_cnt;
        w_nx_ratio  = r_ratio;
        w_nx_os     = r_os;
        w_nx_data   = r_data;
        w_nx_fcnt   = r_frame_cnt;
        w_nx_last   = r_last_acc;
        w_nx_cc_ret = r_cc_ret;
        case (r_state)
            ST_IDLE: begin
                w_nx_os   = I;
                w_nx_data = '0;
                if (w_cc_req) begin
                    w_nx_state  = ST_CC;
                    w_nx_cnt    = '0;
                    w_nx_os     = CC;
                    w_nx_cc_ret = 1'b0;
                end else if (s_axis_tvalid) begin
                    w_nx_state = ST_SOF;
                    w_nx_cnt   = '0;
                    w_nx_os    = SCP;
                    w_nx_ratio = w_ratio_sel;
                    w_nx_last  = 1'b0;
                end
            end
            ST_SOF: begin
                if (r_cnt != SCP_LAST) begin
                    w_nx_cnt = r_cnt + CNT_W'(1);
                end else begin
                    w_nx_state = ST_STREAM;
                    w_nx_cnt   = '0;
                    w_nx_os    = w_accept ? NONE : I;
                    w_nx_data  = w_accept ? s_axis_tdata : '0;
                    w_nx_last  = w_accept && s_axis_tlast;
                end
            end
            ST_STREAM: begin
                if (!w_slot_end) begin
                    w_nx_cnt = r_cnt + CNT_W'(1);
                end else if (r_last_acc) begin
                    w_nx_state = ST_EOF;
                    w_nx_cnt   = '0;
                    w_nx_os    = ECP;
                    w_nx_data  = '0;
                end else if (w_cc_req) begin
                    w_nx_state  = ST_CC;
                    w_nx_cnt    = '0;
                    w_nx_os     = CC;
                    w_nx_data   = '0;
                    w_nx_cc_ret = 1'b1;
                end else begin
                    // No beat offered at the boundary: the next slot is idle fill.
                    w_nx_cnt  = '0;
                    w_nx_os   = w_accept ? NONE : I;
                    w_nx_data = w_accept ? s_axis_tdata : '0;
                    w_nx_last = w_accept && s_axis_tlast;
                end
            end
            ST_EOF: begin
                if (r_cnt != ECP_LAST) begin
                    w_nx_cnt = r_cnt + CNT_W'(1);
                end else begin
                    w_nx_fcnt = sat_inc16(r_frame_cnt);
                    w_nx_cnt  = '0;
                    if (s_axis_tvalid) begin
                        w_nx_state = ST_SOF;
                        w_nx_os    = SCP;
                        w_nx_ratio = w_ratio_sel;
                        w_nx_last  = 1'b0;
                    end else begin
                        w_nx_state = ST_IDLE;
                        w_nx_os    = I;
                    end
                end
            end
            ST_CC: begin
                if (r_cnt != CC_LAST) begin
                    w_nx_cnt = r_cnt + CNT_W'(1);
                end else if (r_cc_ret) begin
                    w_nx_state = ST_STREAM;
                    w_nx_cnt   = '0;
                    w_nx_os    = w_accept ? NONE : I;
                    w_nx_data  = w_accept ? s_axis_tdata : '0;
                    w_nx_last  = w_accept && s_axis_tlast;
                end else begin
                    w_nx_state = ST_IDLE;
                    w_nx_cnt   = '0;
                    w_nx_os    = I;
                end
            end
            default: begin
                w_nx_state = ST_IDLE;
                w_nx_cnt   = '0;
                w_nx_os    = I;
                w_nx_data  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ratio     <= CNT_W'(MULTI_RATIO);
            r_os        <= NONE;
            r_data      <= '0;
            r_frame_cnt <= '0;
            r_last_acc  <= 1'b0;
            r_cc_ret    <= 1'b0;
        end else begin
            r_state     <= w_nx_state;
            r_cnt       <= w_nx_cnt;
            r_ratio     <= w_nx_ratio;
            r_os        <= w_nx_os;
            r_data      <= w_nx_data;
            r_frame_cnt <= w_nx_fcnt;
            r_last_acc  <= w_nx_last;
            r_cc_ret    <= w_nx_cc_ret;
        end
    end

    assign s_axis_tready = w_tready;
    assign os_out        = r_os;
    assign data_out      = r_data;
    assign frame_cnt     = r_frame_cnt;

endmodule

`default_nettype wire
